// File: rtl/code_scorer.sv
// ---------------------------------------------------------------------------
// code_scorer
//
// Scoring stage for the four-peg code-guessing game. A rising edge on setVal
// stores the current pegs as the secret and starts a new game. A rising edge
// on Test captures the current pegs as a guess and scores it over six cycles:
// one cycle for exact (red) matches, four cycles for colour-only (white)
// matches (one guess slot per cycle), and one cycle to publish the result.
//
// Ports:
//   clk         system clock, rising edge
//   Reset       synchronous, active-high reset
//   L1..L4      current peg colours (3 bits each), slot 1 is L1
//   setVal      level input, rising edge stores the secret
//   Test        level input, rising edge scores a guess
//   Red         exact matches of the last scored guess
//   White       colour-only matches of the last scored guess
//   scoreValid  one-cycle pulse when a score completes
//   busy        high while a score is in progress
//   Tries       guesses scored since the last secret
//   Win         sticky, a guess scored four reds
//   Lose        sticky, MAX_TRIES guesses used without a win
// ---------------------------------------------------------------------------
module code_scorer #(
    parameter int MAX_TRIES = 8
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic [2:0] L1,
    input  logic [2:0] L2,
    input  logic [2:0] L3,
    input  logic [2:0] L4,
    input  logic       setVal,
    input  logic       Test,
    output logic [2:0] Red,
    output logic [2:0] White,
    output logic       scoreValid,
    output logic       busy,
    output logic [3:0] Tries,
    output logic       Win,
    output logic       Lose
);

    typedef enum logic [1:0] {
        IDLE,
        EXACT,
        PARTIAL,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic        setVal_q, setVal_d;
    logic        Test_q, Test_d;
    logic        armed_q, armed_d;
    logic [11:0] secret_q, secret_d;
    logic [11:0] guess_q, guess_d;
    logic [3:0]  s_used_q, s_used_d;
    logic [3:0]  g_used_q, g_used_d;
    logic [1:0]  i_q, i_d;
    logic [2:0]  Red_q, Red_d;
    logic [2:0]  White_q, White_d;
    logic        scoreValid_q, scoreValid_d;
    logic [3:0]  Tries_q, Tries_d;
    logic        Win_q, Win_d;
    logic        Lose_q, Lose_d;

    logic        set_event;
    logic        test_event;
    logic [2:0]  secret_peg [4];
    logic [2:0]  guess_peg [4];
    logic [3:0]  exact_match;
    logic [2:0]  red_cnt;
    logic        found;

    // Slot k of the packed registers lives at bits [3k+2:3k]; slot 1 (L1)
    // is index 0 so "lowest index" in the white search means leftmost peg.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            secret_peg[k]  = secret_q[k*3 +: 3];
            guess_peg[k]   = guess_q[k*3 +: 3];
            exact_match[k] = (secret_q[k*3 +: 3] == guess_q[k*3 +: 3]);
        end
    end

    assign set_event  = setVal & ~setVal_q;
    assign test_event = Test & ~Test_q;

    always_comb begin
        state_d      = state_q;
        setVal_d     = setVal;
        Test_d       = Test;
        armed_d      = armed_q;
        secret_d     = secret_q;
        guess_d      = guess_q;
        s_used_d     = s_used_q;
        g_used_d     = g_used_q;
        i_d          = i_q;
        Red_d        = Red_q;
        White_d      = White_q;
        scoreValid_d = 1'b0;
        Tries_d      = Tries_q;
        Win_d        = Win_q;
        Lose_d       = Lose_q;
        red_cnt      = 3'd0;
        found        = 1'b0;

        case (state_q)
            IDLE: begin
                // setVal beats Test on the same edge; events arriving while
                // busy never reach this state, so they are simply lost.
                if (set_event) begin
                    secret_d = {L4, L3, L2, L1};
                    armed_d  = 1'b1;
                    Tries_d  = 4'd0;
                    Win_d    = 1'b0;
                    Lose_d   = 1'b0;
                    Red_d    = 3'd0;
                    White_d  = 3'd0;
                end else if (test_event && armed_q && !Win_q && !Lose_q) begin
                    guess_d  = {L4, L3, L2, L1};
                    White_d  = 3'd0;
                    s_used_d = 4'd0;
                    g_used_d = 4'd0;
                    state_d  = EXACT;
                end
            end

            EXACT: begin
                // Exact matches consume both the secret and guess slot so the
                // white pass cannot count them a second time.
                for (int k = 0; k < 4; k++) begin
                    red_cnt = red_cnt + {2'b00, exact_match[k]};
                end
                s_used_d = exact_match;
                g_used_d = exact_match;
                Red_d    = red_cnt;
                i_d      = 2'd0;
                state_d  = PARTIAL;
            end

            PARTIAL: begin
                // One guess slot per cycle: claim the first unclaimed secret
                // slot of the same colour, which handles duplicate colours.
                if (!g_used_q[i_q]) begin
                    for (int j = 0; j < 4; j++) begin
                        if (!found && !s_used_q[j] &&
                            (secret_peg[j] == guess_peg[i_q])) begin
                            found       = 1'b1;
                            s_used_d[j] = 1'b1;
                        end
                    end
                    if (found) begin
                        White_d = White_q + 3'd1;
                    end
                end
                if (i_q == 2'd3) begin
                    state_d = DONE;
                end else begin
                    i_d = i_q + 2'd1;
                end
            end

            DONE: begin
                scoreValid_d = 1'b1;
                Tries_d      = Tries_q + 4'd1;
                if (Red_q == 3'd4) begin
                    Win_d = 1'b1;
                end else if (Tries_d == 4'(MAX_TRIES)) begin
                    Lose_d = 1'b1;
                end
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            setVal_q     <= 1'b0;
            Test_q       <= 1'b0;
            armed_q      <= 1'b0;
            secret_q     <= 12'd0;
            guess_q      <= 12'd0;
            s_used_q     <= 4'd0;
            g_used_q     <= 4'd0;
            i_q          <= 2'd0;
            Red_q        <= 3'd0;
            White_q      <= 3'd0;
            scoreValid_q <= 1'b0;
            Tries_q      <= 4'd0;
            Win_q        <= 1'b0;
            Lose_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            setVal_q     <= setVal_d;
            Test_q       <= Test_d;
            armed_q      <= armed_d;
            secret_q     <= secret_d;
            guess_q      <= guess_d;
            s_used_q     <= s_used_d;
            g_used_q     <= g_used_d;
            i_q          <= i_d;
            Red_q        <= Red_d;
            White_q      <= White_d;
            scoreValid_q <= scoreValid_d;
            Tries_q      <= Tries_d;
            Win_q        <= Win_d;
            Lose_q       <= Lose_d;
        end
    end

    assign Red        = Red_q;
    assign White      = White_q;
    assign scoreValid = scoreValid_q;
    assign busy       = (state_q != IDLE);
    assign Tries      = Tries_q;
    assign Win        = Win_q;
    assign Lose       = Lose_q;

endmodule

// File: tb/tb_code_scorer.sv
// ---------------------------------------------------------------------------
// tb_code_scorer
//
// Self-checking bench for code_scorer. A table of secret/guess pairs with
// hand-scored red/white counts drives the main loop; short hand-written
// sequences cover run-out, arming, busy drops, setVal/Test collisions and
// reset in the middle of a score.
// ---------------------------------------------------------------------------
module tb_code_scorer;

    logic       clk;
    logic       Reset;
    logic [2:0] L1, L2, L3, L4;
    logic       setVal;
    logic       Test;
    logic [2:0] Red;
    logic [2:0] White;
    logic       scoreValid;
    logic       busy;
    logic [3:0] Tries;
    logic       Win;
    logic       Lose;

    int numChecks;
    int numFails;

    code_scorer #(.MAX_TRIES(8)) dut (
        .clk        (clk),
        .Reset      (Reset),
        .L1         (L1),
        .L2         (L2),
        .L3         (L3),
        .L4         (L4),
        .setVal     (setVal),
        .Test       (Test),
        .Red        (Red),
        .White      (White),
        .scoreValid (scoreValid),
        .busy       (busy),
        .Tries      (Tries),
        .Win        (Win),
        .Lose       (Lose)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something in the bench itself stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic [2:0] s1, s2, s3, s4;
        logic [2:0] g1, g2, g3, g4;
        int         expRed;
        int         expWhite;
        int         expWin;
    } vector_t;

    vector_t vecs [8];

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        numChecks++;
        if (act != exp) begin
            numFails++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic setPegs(input logic [2:0] a, input logic [2:0] b,
                           input logic [2:0] c, input logic [2:0] d);
        L1 = a;
        L2 = b;
        L3 = c;
        L4 = d;
    endtask

    task automatic setSecret(input logic [2:0] a, input logic [2:0] b,
                             input logic [2:0] c, input logic [2:0] d);
        setPegs(a, b, c, d);
        setVal = 1'b1;
        tick();
        setVal = 1'b0;
        tick();
    endtask

    task automatic pulseTest();
        Test = 1'b1;
        tick();
        Test = 1'b0;
    endtask

    // Counts busy and scoreValid highs over a window of cycles.
    task automatic observe(input int cycles, output int busyCnt, output int svCnt);
        busyCnt = 0;
        svCnt   = 0;
        for (int k = 0; k < cycles; k++) begin
            if (busy) busyCnt++;
            if (scoreValid) svCnt++;
            tick();
        end
    endtask

    // Scores one guess and checks the whole C..C+7 timeline. The pegs are
    // scrambled right after edge C to show only the captured guess counts.
    task automatic applyStimulus(input logic [2:0] g1, input logic [2:0] g2,
                                 input logic [2:0] g3, input logic [2:0] g4,
                                 input int expRed, input int expWhite,
                                 input int expTries, input int expWin,
                                 input int expLose);
        setPegs(g1, g2, g3, g4);
        pulseTest();
        checkOutput("busy after C", int'(busy), 1);
        setPegs(3'd7, 3'd7, 3'd7, 3'd7);
        for (int n = 1; n <= 6; n++) begin
            tick();
            if (n == 1) checkOutput("Red at C+1", int'(Red), expRed);
            if (n == 5) checkOutput("White at C+5", int'(White), expWhite);
            checkOutput($sformatf("busy at C+%0d", n), int'(busy), (n < 6) ? 1 : 0);
            checkOutput($sformatf("scoreValid at C+%0d", n), int'(scoreValid),
                        (n == 6) ? 1 : 0);
        end
        checkOutput("Red at C+6", int'(Red), expRed);
        checkOutput("White at C+6", int'(White), expWhite);
        checkOutput("Tries at C+6", int'(Tries), expTries);
        checkOutput("Win at C+6", int'(Win), expWin);
        checkOutput("Lose at C+6", int'(Lose), expLose);
        tick();
        checkOutput("scoreValid at C+7", int'(scoreValid), 0);
    endtask

    initial begin
        int busyCnt;
        int svCnt;

        numChecks = 0;
        numFails  = 0;
        Reset     = 1'b1;
        setVal    = 1'b0;
        Test      = 1'b0;
        setPegs(3'd0, 3'd0, 3'd0, 3'd0);

        vecs[0] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd2, 3'd3, 3'd4, 4, 0, 1};
        vecs[1] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd1, 3'd1, 0, 4, 0};
        vecs[2] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd1, 3'd3, 3'd1, 3'd1, 1, 2, 0};
        vecs[3] = '{3'd5, 3'd6, 3'd7, 3'd0, 3'd0, 3'd7, 3'd6, 3'd5, 0, 4, 0};
        vecs[4] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd2, 3'd4, 3'd3, 2, 2, 0};
        vecs[5] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd7, 3'd7, 3'd7, 0, 0, 0};
        vecs[6] = '{3'd3, 3'd3, 3'd3, 3'd1, 3'd3, 3'd1, 3'd2, 3'd2, 1, 1, 0};
        vecs[7] = '{3'd2, 3'd4, 3'd4, 3'd6, 3'd4, 3'd4, 3'd4, 3'd4, 2, 0, 0};

        // Reset state.
        tick();
        tick();
        checkOutput("reset Red", int'(Red), 0);
        checkOutput("reset White", int'(White), 0);
        checkOutput("reset scoreValid", int'(scoreValid), 0);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset Tries", int'(Tries), 0);
        checkOutput("reset Win", int'(Win), 0);
        checkOutput("reset Lose", int'(Lose), 0);
        Reset = 1'b0;
        tick();

        // Test before any secret is stored must not start a score.
        $display("[TB] Test before setVal");
        setPegs(3'd1, 3'd2, 3'd3, 3'd4);
        pulseTest();
        observe(8, busyCnt, svCnt);
        checkOutput("unarmed busy count", busyCnt, 0);
        checkOutput("unarmed scoreValid count", svCnt, 0);

        // Table of scored guesses, each in a fresh game.
        $display("[TB] vector table");
        for (int v = 0; v < 8; v++) begin
            setSecret(vecs[v].s1, vecs[v].s2, vecs[v].s3, vecs[v].s4);
            checkOutput($sformatf("vec%0d Tries after setVal", v), int'(Tries), 0);
            checkOutput($sformatf("vec%0d Red after setVal", v), int'(Red), 0);
            applyStimulus(vecs[v].g1, vecs[v].g2, vecs[v].g3, vecs[v].g4,
                          vecs[v].expRed, vecs[v].expWhite, 1, vecs[v].expWin, 0);
        end

        // After a win a further Test is ignored.
        $display("[TB] Test after win");
        setSecret(3'd1, 3'd2, 3'd3, 3'd4);
        applyStimulus(3'd1, 3'd2, 3'd3, 3'd4, 4, 0, 1, 1, 0);
        setPegs(3'd1, 3'd2, 3'd3, 3'd4);
        pulseTest();
        observe(8, busyCnt, svCnt);
        checkOutput("post-win busy count", busyCnt, 0);
        checkOutput("post-win scoreValid count", svCnt, 0);
        checkOutput("post-win Tries", int'(Tries), 1);
        checkOutput("post-win Win", int'(Win), 1);

        // Run out of tries.
        $display("[TB] run-out");
        setSecret(3'd7, 3'd7, 3'd7, 3'd7);
        checkOutput("new game clears Win", int'(Win), 0);
        for (int t = 1; t <= 8; t++) begin
            applyStimulus(3'd0, 3'd0, 3'd0, 3'd0, 0, 0, t, 0, (t == 8) ? 1 : 0);
        end
        pulseTest();
        observe(10, busyCnt, svCnt);
        checkOutput("9th Test busy count", busyCnt, 0);
        checkOutput("9th Test scoreValid count", svCnt, 0);
        checkOutput("9th Test Tries", int'(Tries), 8);
        setSecret(3'd7, 3'd7, 3'd7, 3'd7);
        checkOutput("setVal clears Tries", int'(Tries), 0);
        checkOutput("setVal clears Lose", int'(Lose), 0);

        // Test re-pulsed at C+2 is dropped.
        $display("[TB] re-pulse while busy");
        setSecret(3'd1, 3'd2, 3'd3, 3'd4);
        setPegs(3'd4, 3'd3, 3'd2, 3'd1);
        pulseTest();
        tick();
        Test = 1'b1;
        tick();
        Test = 1'b0;
        observe(14, busyCnt, svCnt);
        checkOutput("re-pulse scoreValid count", svCnt, 1);
        checkOutput("re-pulse Tries", int'(Tries), 1);
        checkOutput("re-pulse White", int'(White), 4);
        checkOutput("re-pulse busy after", int'(busy), 0);

        // setVal and Test on the same edge: secret stored, no score.
        $display("[TB] setVal and Test together");
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        setPegs(3'd2, 3'd5, 3'd6, 3'd1);
        setVal = 1'b1;
        Test   = 1'b1;
        tick();
        setVal = 1'b0;
        Test   = 1'b0;
        observe(8, busyCnt, svCnt);
        checkOutput("collision busy count", busyCnt, 0);
        checkOutput("collision scoreValid count", svCnt, 0);
        applyStimulus(3'd2, 3'd5, 3'd6, 3'd1, 4, 0, 1, 1, 0);

        // Reset in the middle of a score.
        $display("[TB] reset at C+3");
        setSecret(3'd1, 3'd2, 3'd3, 3'd4);
        setPegs(3'd1, 3'd2, 3'd3, 3'd4);
        pulseTest();
        tick();
        checkOutput("pre-reset Red", int'(Red), 4);
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checkOutput("mid-reset Red", int'(Red), 0);
        checkOutput("mid-reset White", int'(White), 0);
        checkOutput("mid-reset busy", int'(busy), 0);
        checkOutput("mid-reset Tries", int'(Tries), 0);
        checkOutput("mid-reset Win", int'(Win), 0);
        checkOutput("mid-reset scoreValid", int'(scoreValid), 0);
        observe(8, busyCnt, svCnt);
        checkOutput("aborted scoreValid count", svCnt, 0);
        pulseTest();
        observe(8, busyCnt, svCnt);
        checkOutput("post-reset Test busy count", busyCnt, 0);
        checkOutput("post-reset Tries", int'(Tries), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule

// File: doc/code_scorer.md
# code_scorer

Scoring stage for the four-peg code-guessing game. It sits directly downstream of the peg-select block, which produces four 3-bit peg colours from the player buttons. This block captures the secret code on `setVal` and scores each guess on `Test` using standard red/white rules (red = right colour, right slot; white = right colour, wrong slot). It also counts attempts and flags win or lose.

## Interface
- `MAX_TRIES`, 8: guesses allowed per secret; legal range 1..15.
- `clk`  in  1: system clock; all state changes on the rising edge.
- `Reset`  in  1: synchronous, active-high reset.
- `L1`, `L2`, `L3`, `L4`  in  3 each: current peg colours from the peg-select stage; slot 1 is `L1`.
- `setVal`  in  1: level input; a rising edge stores `L1..L4` as the secret.
- `Test`  in  1: level input; a rising edge scores `L1..L4` against the secret.
- `Red`  out  3: exact matches of the last scored guess, 0..4.
- `White`  out  3: colour-only matches of the last scored guess, 0..4.
- `scoreValid`  out  1: one-cycle pulse when `Red`/`White` update.
- `busy`  out  1: high while a score is in progress.
- `Tries`  out  4: guesses scored since the last secret.
- `Win`  out  1: sticky; set when a guess scores `Red` = 4.
- `Lose`  out  1: sticky; set when `Tries` reaches `MAX_TRIES` without a win.

## Operation
- Edge detection:
  - `setVal` and `Test` are registered each cycle into `setVal_q` and `Test_q`.
  - An event fires when the input is 1 and its registered copy is 0.
  - Inputs are synchronous to `clk`; debouncing is upstream's job.
- Internal state:
  - `armed` flag, 12-bit secret register, 12-bit guess register.
  - Per-slot flags `sUsed[3:0]` and `gUsed[3:0]`.
  - Slot index `i` (2 bits).
- FSM states: IDLE, EXACT, PARTIAL, DONE.
- IDLE:
  - A `setVal` event stores the secret and sets `armed` = 1.
  - The same event clears `Tries`, `Win`, `Lose`, `Red` and `White`.
  - A `Test` event is accepted only when `armed` = 1, `Win` = 0 and `Lose` = 0.
  - On acceptance: capture the guess, clear `White`, clear both used-flag sets, go to EXACT.
- EXACT (1 cycle):
  - For each slot k where guess[k] == secret[k], set `sUsed[k]` and `gUsed[k]`.
  - `Red` gets the popcount of those matches.
  - Set `i` = 0 and go to PARTIAL.
- PARTIAL (4 cycles, `i` = 0..3):
  - Skip the slot if `gUsed[i]` is set.
  - Otherwise find the lowest-index secret slot j with `sUsed[j]` = 0 and secret[j] == guess[i].
  - If found, set `sUsed[j]` and increment `White`.
  - After `i` = 3, go to DONE.
- DONE (1 cycle):
  - Pulse `scoreValid`.
  - `Tries` = `Tries` + 1.
  - Set `Win` if `Red` == 4; otherwise set `Lose` if the new `Tries` == `MAX_TRIES`.
  - Return to IDLE.
- Arithmetic: `Red` + `White` ≤ 4 always. `Tries` never exceeds `MAX_TRIES` because no `Test` is accepted once `Lose` is set.
- `busy` = 1 in EXACT, PARTIAL and DONE.

## Timing
- Reset values:
  - All outputs 0; `armed` = 0; FSM in IDLE.
  - Secret, guess and used-flag registers 0; `setVal_q` and `Test_q` 0.
- Latency: call the clock edge that accepts `Test` edge C.
  - `busy` is high from after edge C until edge C+6.
  - `Red` updates at C+1.
  - `White` is final at C+5.
  - `scoreValid`, `Tries`, `Win` and `Lose` update at C+6; `scoreValid` is high for exactly that one cycle.
- `L1..L4` are sampled only at edge C; changes afterwards do not affect the score in progress.
- Event arbitration:
  - `Test` or `setVal` events while `busy` = 1 are dropped; they are not queued.
  - A level still held high after `busy` falls does not retrigger.
  - If `setVal` and `Test` events occur on the same edge in IDLE, `setVal` wins and `Test` is dropped.
- Reset has priority over all events. `Reset` asserted mid-score aborts the score: no `scoreValid` pulse, `Tries` not incremented.
- `setVal` is accepted after `Win` or `Lose` and starts a new game.

## Test plan
- Secret {1,2,3,4}, guess {1,2,3,4}:
  - `Red`=4, `White`=0; `scoreValid` at C+6; `Win`=1, `Tries`=1.
  - A further `Test` is ignored.
- Secret {1,1,2,2}, guess {2,2,1,1}: `Red`=0, `White`=4, `Win`=0.
- Secret {1,1,2,3}, guess {1,3,1,1}: `Red`=1, `White`=2 (duplicate handling).
- Run-out, with `MAX_TRIES`=8 and secret {7,7,7,7}:
  - Eight guesses of {0,0,0,0}: the 8th gives `Tries`=8, `Lose`=1.
  - A 9th `Test` gives no `busy` and no `scoreValid`.
  - A following `setVal` clears `Tries` and `Lose`.
- Edge cases around arming and busy:
  - `Test` before any `setVal` gives no `busy`.
  - `Test` re-pulsed at C+2 is dropped: exactly one `scoreValid`.
  - `setVal` and `Test` on the same edge: secret stored, no score.
- `Reset` at C+3 during a score:
  - Next cycle all outputs are 0 and `busy`=0.
  - No `scoreValid` occurs.
  - A `Test` afterwards is ignored until a new `setVal`.
